mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master arbiter and access sequencer for the shared external SRAM bus (16-bit address, 16-bit data, active-low {we, ce, oe, lb, ub} strobes).
- Master 0 is the CPU's non-I/O memory path. Master 1 is a secondary requester such as a DMA or display-refresh engine.
- Round-robin grant, fixed multi-cycle access timing, one-cycle ack pulse per completed transaction.
- Drives the SRAM strobes, address, write data, and the transceiver output-enable for the data bus.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
WAIT_CYCLES, 2, cycles strobes are held active per access (legal range 1..15)

Ports:
clk  in  1  rising-edge clock
reset  in  1  reset, synchronous, active-high
req0  in  1  master 0 request; held high until ack0
we0  in  1  master 0: 1 = write, 0 = read; stable while req0 high
addr0  in  ADDR_W  master 0 address; stable while req0 high
wdata0  in  DATA_W  master 0 write data; stable while req0 high
ack0  out  1  one-cycle completion pulse to master 0
req1, we1, addr1, wdata1, ack1  same as master 0, for master 1
rdata  out  DATA_W  registered read data; valid in the ack cycle and held until the next read completes
mem_addr  out  ADDR_W  SRAM address
mem_wdata  out  DATA_W  data driven toward the SRAM
mem_rdata  in  DATA_W  data returned from the SRAM (transceiver input side)
mem_drive  out  1  transceiver output enable; 1 = drive mem_wdata onto the bus
mem_control  out  5  {we, ce, oe, lb, ub}, active-low

Behaviour:
- Reset (synchronous, active-high) values:
  - state = IDLE, last_grant = 1 (so master 0 wins the first tie).
  - ack0 = ack1 = 0, rdata = 0, mem_addr = 0, mem_wdata = 0, mem_drive = 0.
  - mem_control = 5'b11111.
- Reset asserted mid-access aborts the access immediately. No ack is issued; the master must reissue.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE:
    - Strobes are 11111 and mem_drive is 0.
    - At the clock edge, if any req is high: choose the grantee, latch its addr/we/wdata into mem_addr/mem_wdata/op, set cnt = WAIT_CYCLES-1, go to ACCESS.
    - Otherwise stay in IDLE.
  - ACCESS:
    - Read strobes are 5'b10000 (we=1, ce=0, oe=0, lb=ub=0) with mem_drive = 0.
    - Write strobes are 5'b00100 (we=0, ce=0, oe=1, lb=ub=0) with mem_drive = 1.
    - If cnt != 0: decrement cnt.
    - If cnt == 0: on a read, capture mem_rdata into rdata. Then go to DONE and register ack for the grantee.
  - DONE:
    - Strobes are 11111 and mem_drive is 0.
    - Grantee's ack = 1 for exactly this cycle; next state is IDLE unconditionally.
- Requester handshake:
  - The requester drops req on the edge where it samples ack.
  - req therefore is already low in the following IDLE cycle, so no double service occurs.
  - A requester may raise req again from the cycle after DONE.
- Arbitration (in IDLE only):
  - Only one req high: grant it.
  - Both high: grant the master that is not last_grant.
  - last_grant updates on every grant.
  - Requests arriving during ACCESS/DONE wait. A waiting master is always served no later than the next transaction: no starvation.
- Latency: req high in IDLE cycle t, so ACCESS occupies cycles t+1..t+WAIT_CYCLES and ack is high in cycle t+WAIT_CYCLES+1. Throughput is one access per WAIT_CYCLES+2 cycles.
- Stability: mem_addr, mem_wdata and the op are latched at grant and do not change during ACCESS, even if the requester's inputs change.
- ack0 and ack1 are never high in the same cycle.
- Strobes never go active outside ACCESS.
- rdata is not modified by write transactions.

Test Plan:
- Reset then idle, no reqs → mem_control=11111, mem_drive=0, ack0=ack1=0, rdata=0 held for 10 cycles.
- WAIT_CYCLES=2; req0 read addr 0x0040, mem_rdata model returns 0xBEEF → mem_control=10000 for exactly 2 cycles, ack0 high in the 3rd cycle after req, rdata=0xBEEF, mem_addr=0x0040.
- req1 write addr 0x1234 data 0x00A5 → mem_control=00100 and mem_drive=1 for 2 cycles, mem_wdata=0x00A5, ack1 one cycle, rdata unchanged.
- req0 and req1 both raised in the same IDLE cycle, each re-requesting immediately after its ack, 4 transactions → grant order 0,1,0,1; acks never overlap.
- req1 raised during master 0's ACCESS → master 1 served in the next IDLE; ack1 exactly WAIT_CYCLES+2 cycles after master 0's ack.
- reset asserted in the 2nd ACCESS cycle → next cycle: IDLE, mem_control=11111, mem_drive=0, no ack; reissued req completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter and fixed-timing access sequencer for the shared SRAM bus.
// Handshake: a master holds req (and its we/addr/wdata) until it sees its one-cycle ack.
module mem_bus_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_drive,
   output logic [4:0]        mem_control,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // {we, ce, oe, lb, ub}, active-low
   localparam logic [4:0] CTRL_IDLE  = 5'b11111;
   localparam logic [4:0] CTRL_READ  = 5'b10000;
   localparam logic [4:0] CTRL_WRITE = 5'b00100;

   state_t     st;
   logic       last_grant;
   logic       grantee;
   logic       op_we;
   logic [3:0] cnt;

   logic              grant_sel;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // On a tie the master that was not served last wins, which bounds any wait to one transaction.
   always_comb begin
      grant_sel = (req0 && req1) ? ~last_grant : req1;
      sel_we    = grant_sel ? we1 : we0;
      sel_addr  = grant_sel ? addr1 : addr0;
      sel_wdata = grant_sel ? wdata1 : wdata0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st          <= IDLE;
         last_grant  <= 1'b1;
         grantee     <= 1'b0;
         op_we       <= 1'b0;
         cnt         <= '0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         rdata       <= '0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_drive   <= 1'b0;
         mem_control <= CTRL_IDLE;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (st)
            IDLE: begin
               if (req0 || req1) begin
                  grantee     <= grant_sel;
                  last_grant  <= grant_sel;
                  op_we       <= sel_we;
                  mem_addr    <= sel_addr;
                  mem_wdata   <= sel_wdata;
                  cnt         <= 4'(WAIT_CYCLES - 1);
                  mem_control <= sel_we ? CTRL_WRITE : CTRL_READ;
                  mem_drive   <= sel_we;
                  st          <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  if (!op_we) rdata <= mem_rdata;
                  if (grantee) ack1 <= 1'b1;
                  else         ack0 <= 1'b1;
                  mem_control <= CTRL_IDLE;
                  mem_drive   <= 1'b0;
                  st          <= DONE;
               end
            end
            DONE: begin
               st <= IDLE;
            end
            default: begin
               st          <= IDLE;
               mem_control <= CTRL_IDLE;
               mem_drive   <= 1'b0;
            end
         endcase
      end
   end

   assign state = st;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: stimulus pushes expected transactions, a negedge monitor
// pops one per ack and checks master, cycle, address, data and strobe timing.
module tb_mem_bus_arbiter;

   localparam int W  = 2;
   localparam int EW = 66;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, we0, req1, we1;
   logic [15:0] addr0, wdata0, addr1, wdata1;
   logic        ack0, ack1, mem_drive;
   logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic [4:0]  mem_control;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int acc_cnt = 0;
   logic [4:0] last_pat = 5'b11111;

   // {master, write, addr[16], rdata[16], wdata[16], cycle[16]}
   logic [EW-1:0] exp_q[$];

   mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
      .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_drive(mem_drive), .mem_control(mem_control), .state(state)
   );

   // ---- clock / reset ----
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: one fixed word, everything else derived from the address
   always_comb mem_rdata = (mem_addr == 16'h0040) ? 16'hBEEF : (mem_addr ^ 16'h5A5A);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic exp_push(input bit m, input bit w, input logic [15:0] a, input logic [15:0] rd,
                           input logic [15:0] wd, input int c);
      exp_q.push_back({m, w, a, rd, wd, 16'(c)});
   endtask

   // ---- driver ----
   task automatic do_req(input bit m, input bit w, input logic [15:0] a, input logic [15:0] d);
      bit got = 1'b0;
      if (!m) begin we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
      else    begin we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
      for (int i = 0; i < 60 && !got; i++) begin
         tick();
         if (m ? ack1 : ack0) got = 1'b1;
      end
      tick();
      if (!m) req0 = 1'b0;
      else    req1 = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: master %0d got no ack within 60 cycles", m);
      end
   endtask

   // ---- monitor / scoreboard ----
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (reset) begin
         acc_cnt = 0;
      end else begin
         if (mem_control != 5'b11111) begin
            acc_cnt++;
            last_pat = mem_control;
         end
         check("drive_vs_strobes", {31'd0, mem_drive}, {31'd0, mem_control == 5'b00100});
         if (ack0 && ack1) check("ack_overlap", 32'd1, 32'd0);
         if (ack0 || ack1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("ack_master", {31'd0, ack1}, {31'd0, e[65]});
               check("ack_cycle", 32'(cyc & 16'hFFFF), {16'd0, e[15:0]});
               check("mem_addr", {16'd0, mem_addr}, {16'd0, e[63:48]});
               check("rdata", {16'd0, rdata}, {16'd0, e[47:32]});
               if (e[64]) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, e[31:16]});
               check("access_cycles", 32'(acc_cnt), 32'(W));
               check("access_strobes", {27'd0, last_pat}, {27'd0, e[64] ? 5'b00100 : 5'b10000});
            end
            acc_cnt = 0;
         end
      end
   end

   // ---- stimulus ----
   initial begin
      int t;
      reset = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      repeat (3) tick();
      reset = 1'b0;

      // idle after reset
      check("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
      check("reset_mem_wdata", {16'd0, mem_wdata}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_control", {27'd0, mem_control}, 32'h1F);
         check("idle_drive", {31'd0, mem_drive}, 32'd0);
         check("idle_acks", {30'd0, ack1, ack0}, 32'd0);
         check("idle_rdata", {16'd0, rdata}, 32'd0);
         check("idle_state", {30'd0, state}, 32'd0);
      end

      // single read by master 0
      t = cyc;
      exp_push(1'b0, 1'b0, 16'h0040, 16'hBEEF, 16'h0000, t + 3);
      do_req(1'b0, 1'b0, 16'h0040, 16'h0000);

      // single write by master 1: rdata untouched
      t = cyc;
      exp_push(1'b1, 1'b1, 16'h1234, 16'hBEEF, 16'h00A5, t + 3);
      do_req(1'b1, 1'b1, 16'h1234, 16'h00A5);

      // simultaneous requests, each re-requesting right after its ack: order 0,1,0,1
      t = cyc;
      exp_push(1'b0, 1'b0, 16'h0100, 16'h5B5A, 16'h0000, t + 3);
      exp_push(1'b1, 1'b1, 16'h0200, 16'h5B5A, 16'h1111, t + 7);
      exp_push(1'b0, 1'b0, 16'h0102, 16'h5B58, 16'h0000, t + 11);
      exp_push(1'b1, 1'b1, 16'h0202, 16'h5B58, 16'h2222, t + 15);
      fork
         begin
            do_req(1'b0, 1'b0, 16'h0100, 16'h0000);
            do_req(1'b0, 1'b0, 16'h0102, 16'h0000);
         end
         begin
            do_req(1'b1, 1'b1, 16'h0200, 16'h1111);
            do_req(1'b1, 1'b1, 16'h0202, 16'h2222);
         end
      join

      // master 1 arrives during master 0's access: served WAIT_CYCLES+2 after ack0
      t = cyc;
      exp_push(1'b0, 1'b0, 16'h0300, 16'h595A, 16'h0000, t + 3);
      exp_push(1'b1, 1'b1, 16'h0400, 16'h595A, 16'h3333, t + 3 + W + 2);
      fork
         do_req(1'b0, 1'b0, 16'h0300, 16'h0000);
         begin
            tick();
            do_req(1'b1, 1'b1, 16'h0400, 16'h3333);
         end
      join

      // reset in the second access cycle aborts without an ack
      t = cyc;
      we0 = 1'b0; addr0 = 16'h0500; wdata0 = 16'h0000; req0 = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("abort_state", {30'd0, state}, 32'd0);
      check("abort_control", {27'd0, mem_control}, 32'h1F);
      check("abort_drive", {31'd0, mem_drive}, 32'd0);
      check("abort_ack", {30'd0, ack1, ack0}, 32'd0);
      check("abort_rdata", {16'd0, rdata}, 32'd0);
      reset = 1'b0;
      exp_push(1'b0, 1'b0, 16'h0500, 16'h5F5A, 16'h0000, t + 6);
      do_req(1'b0, 1'b0, 16'h0500, 16'h0000);

      repeat (5) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
